regfile_wb_arbiter: RTL and testbench

- Owns the single write port (regwrite/wa/wd) of the 8x8 register file, $zero plus $s1..$s7.
- After reset, sequences an initialisation sweep that writes INIT_VAL to registers 1..NREG-1.
- Then shares the write port between two writeback requesters (req 0 = ALU, req 1 = load unit) using valid/ready handshakes and round-robin arbitration.
- All write-port outputs are registered; one write at most per cycle.

---
 rtl/regfile_wb_arbiter_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned DW   = 8;

  localparam logic [DW-1:0] INIT_VAL = 8'h00;
  localparam logic [AW-1:0] REG_ZERO = '0;
  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : regfile_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester handshakes plus the register-file write port.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;

  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;

  logic          regwrite;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          init_done;

  // Requesters and register file side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  regwrite, wa, wd, init_done
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output regwrite, wa, wd, init_done
  );

endinterface : regfile_wb_arbiter_if

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin grant; rr_last remembers the last granted index.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic rr_last;

  // Grant the sole requester, or on contention the one not served last.
  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Update priority only when a transfer actually completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= 1'b1;
    end else if (accept) begin
      rr_last <= grant[1];
    end
  end

endmodule : rr_arb2

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: init sweep after reset, then round-robin writeback.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          init_done_q, init_done_d;

  logic [1:0]    valid;
  logic [1:0]    grant;
  logic [1:0]    ready;
  logic          accept;

  assign valid  = {bus.req1_valid, bus.req0_valid};
  assign ready  = grant & {2{state_q == RUN}};
  assign accept = |(valid & ready);

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  (valid),
    .accept (accept),
    .grant  (grant)
  );

  // Sweep sequencing and write-port next values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    regwrite_d  = 1'b0;
    wa_d        = wa_q;
    wd_d        = wd_q;
    init_done_d = init_done_q;

    unique case (state_q)
      INIT: begin
        regwrite_d = 1'b1;
        wa_d       = ptr_q;
        wd_d       = INIT_VAL;
        if (ptr_q == LAST_REG) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      RUN: begin
        if (accept) begin
          wa_d       = ready[1] ? bus.req1_addr : bus.req0_addr;
          wd_d       = ready[1] ? bus.req1_data : bus.req0_data;
          regwrite_d = (wa_d != REG_ZERO);
        end
      end
      default: state_d = INIT;
    endcase
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      ptr_q       <= AW'(1);
      regwrite_q  <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      regwrite_q  <= regwrite_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.regwrite   = regwrite_q;
  assign bus.wa         = wa_q;
  assign bus.wd         = wd_q;
  assign bus.init_done  = init_done_q;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with a small register-file model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_clear = 1'b1;
  logic [DW-1:0] mem [NREG];
  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file committing the arbiter's write port.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int r = 0; r < int'(NREG); r++) mem[r] <= (r == 0) ? 8'h00 : 8'hEE;
    end else if (bus.regwrite) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
  endtask

  task automatic check_port(input string name, input logic rw, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    n_cmp++;
    if (bus.regwrite !== rw || bus.wa !== a || bus.wd !== d) begin
      n_bad++;
      $display("FAIL %s: got rw=%b wa=%0d wd=%h, want rw=%b wa=%0d wd=%h",
               name, bus.regwrite, bus.wa, bus.wd, rw, a, d);
    end
  endtask

  task automatic do_init();
    idle_reqs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (7) tick();
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    reset = 1'b1;
    tick(); tick();
    check_port("reset_port", 1'b0, 3'd0, 8'h00);
    n_cmp++;
    if (bus.init_done !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got done=%b r0=%b r1=%b want 0 0 0",
               bus.init_done, bus.req0_ready, bus.req1_ready);
    end
    idle_reqs();
  endtask

  task automatic test_sweep();
    logic exp_done;
    mem_clear = 1'b0;
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_port($sformatf("sweep_%0d", i), 1'b1, AW'(i), 8'h00);
      exp_done = (i == 7);
      n_cmp++;
      if (bus.init_done !== exp_done) begin
        n_bad++;
        $display("FAIL sweep_done_%0d: got %b want %b", i, bus.init_done, exp_done);
      end
    end
    tick();
    check_port("sweep_end", 1'b0, 3'd7, 8'h00);
    n_cmp++;
    if (bus.init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL sweep_done_hold: got %b want 1", bus.init_done);
    end
    for (int r = 0; r < int'(NREG); r++) begin
      n_cmp++;
      if (mem[r] !== 8'h00) begin
        n_bad++;
        $display("FAIL sweep_mem_%0d: got %h want 00", r, mem[r]);
      end
    end
  endtask

  task automatic test_init_request();
    logic exp_rdy;
    idle_reqs();
    reset = 1'b1;
    tick();
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd3; bus.req0_data = 8'hA5;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL init_req_ready_0: got %b want 0", bus.req0_ready);
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_rdy = (i == 7);
      n_cmp++;
      if (bus.req0_ready !== exp_rdy) begin
        n_bad++;
        $display("FAIL init_req_ready_%0d: got %b want %b", i, bus.req0_ready, exp_rdy);
      end
    end
    tick();
    bus.req0_valid = 1'b0;
    check_port("init_req_write", 1'b1, 3'd3, 8'hA5);
    tick();
    check_port("init_req_idle", 1'b0, 3'd3, 8'hA5);
  endtask

  task automatic test_contention();
    logic g;
    do_init();
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd2; bus.req0_data = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd5; bus.req1_data = 8'h22;
    #1;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2) == 1;
      n_cmp++;
      if (bus.req0_ready !== ~g || bus.req1_ready !== g) begin
        n_bad++;
        $display("FAIL rr_grant_%0d: got r0=%b r1=%b want r0=%b r1=%b",
                 k, bus.req0_ready, bus.req1_ready, ~g, g);
      end
      tick();
      check_port($sformatf("rr_write_%0d", k), 1'b1, g ? 3'd5 : 3'd2, g ? 8'h22 : 8'h11);
    end
    idle_reqs();
    #1;
  endtask

  task automatic test_addr0();
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd0; bus.req1_data = 8'hFF;
    #1;
    n_cmp++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL addr0_ready: got r0=%b r1=%b want r0=0 r1=1", bus.req0_ready, bus.req1_ready);
    end
    tick();
    idle_reqs();
    check_port("addr0_drop", 1'b0, 3'd0, 8'hFF);
    tick();
    n_cmp++;
    if (mem[0] !== 8'h00) begin
      n_bad++;
      $display("FAIL addr0_mem: got %h want 00", mem[0]);
    end
  endtask

  task automatic test_same_addr();
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd6; bus.req0_data = 8'h33;
    tick();
    idle_reqs();
    check_port("same_prep", 1'b1, 3'd6, 8'h33);
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd4; bus.req0_data = 8'h01;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd4; bus.req1_data = 8'h02;
    #1;
    n_cmp++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL same_grant1: got r0=%b r1=%b want r0=0 r1=1", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req1_valid = 1'b0;
    check_port("same_first", 1'b1, 3'd4, 8'h02);
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL same_grant0: got %b want 1", bus.req0_ready);
    end
    tick();
    idle_reqs();
    check_port("same_second", 1'b1, 3'd4, 8'h01);
    tick();
    n_cmp++;
    if (mem[4] !== 8'h01 || mem[6] !== 8'h33) begin
      n_bad++;
      $display("FAIL same_mem: got reg4=%h reg6=%h want reg4=01 reg6=33", mem[4], mem[6]);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd2; bus.req0_data = 8'h5A;
    tick();
    idle_reqs();
    check_port("mid_accept", 1'b1, 3'd2, 8'h5A);
    reset = 1'b1;
    tick();
    check_port("mid_reset", 1'b0, 3'd0, 8'h00);
    n_cmp++;
    if (bus.init_done !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_done: got %b want 0", bus.init_done);
    end
    reset = 1'b0;
    tick();
    check_port("mid_restart", 1'b1, 3'd1, 8'h00);
  endtask

  initial begin
    idle_reqs();
    test_reset();
    test_sweep();
    test_init_request();
    test_contention();
    test_addr0();
    test_same_addr();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
